// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN result post-processing blocks.
package cnn_pkg;

    localparam int unsigned NUM_CLASS_DEF = 10;
    localparam int unsigned SCORE_W       = 32;

    typedef logic signed [SCORE_W-1:0] score_t;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} argmax_state_e;

endpackage

// File: rtl/cnn_result_argmax.sv
// Argmax over one frame of signed class scores: latch, scan one score per cycle, present result.
// Optional debug read port of the frame buffer is enabled by defining CNN_ARGMAX_DBG_EN.
module cnn_result_argmax
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_CLASS = NUM_CLASS_DEF,
    parameter int unsigned DATA_W    = SCORE_W,
    parameter int unsigned IDX_W     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_res_valid,
    output logic              o_res_ready,
    input  logic [DATA_W-1:0] i_res [NUM_CLASS-1:0],
    output logic              o_cls_valid,
    input  logic              i_cls_ready,
    output logic [IDX_W-1:0]  o_cls_idx,
`ifdef CNN_ARGMAX_DBG_EN
    output logic [DATA_W-1:0] o_cls_score,
    input  logic [IDX_W-1:0]  i_dbg_idx,
    output logic [DATA_W-1:0] o_dbg_score
`else
    output logic [DATA_W-1:0] o_cls_score
`endif
);

    argmax_state_e            r_state;
    argmax_state_e            w_state_next;
    logic signed [DATA_W-1:0] r_buf [NUM_CLASS-1:0];
    logic [IDX_W-1:0]         r_cnt;
    logic [IDX_W-1:0]         r_best_idx;
    logic signed [DATA_W-1:0] r_best;
    logic [IDX_W-1:0]         r_cls_idx;
    logic [DATA_W-1:0]        r_cls_score;
    logic                     w_take;
    logic                     w_gt;
    logic                     w_last;
    logic signed [DATA_W-1:0] w_cand;

    assign w_take = i_res_valid & (r_state == IDLE);
    assign w_cand = r_buf[r_cnt];
    assign w_gt   = w_cand > r_best;
    assign w_last = (r_cnt == IDX_W'(NUM_CLASS - 1));

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_take) w_state_next = SCAN;
            SCAN:    if (w_last) w_state_next = HOLD;
            HOLD:    if (i_cls_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_best_idx  <= '0;
            r_best      <= '0;
            r_cls_idx   <= '0;
            r_cls_score <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_best     <= i_res[0];
                r_best_idx <= '0;
                r_cnt      <= IDX_W'(1);
            end else if (r_state == SCAN) begin
                // Counter parks at 0 after the last compare so the buffer read stays in range.
                r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
                if (w_gt) begin
                    r_best     <= w_cand;
                    r_best_idx <= r_cnt;
                end
                if (w_last) begin
                    r_cls_idx   <= w_gt ? r_cnt : r_best_idx;
                    r_cls_score <= w_gt ? w_cand : r_best;
                end
            end
        end
    end

    // Frame buffer carries no reset; contents are only meaningful after a handshake.
    always_ff @(posedge i_clk) begin
        if (w_take) begin
            for (int i = 0; i < int'(NUM_CLASS); i++) begin
                r_buf[i] <= i_res[i];
            end
        end
    end

    assign o_res_ready = (r_state == IDLE);
    assign o_cls_valid = (r_state == HOLD);
    assign o_cls_idx   = r_cls_idx;
    assign o_cls_score = r_cls_score;

`ifdef CNN_ARGMAX_DBG_EN
    logic [DATA_W-1:0] r_dbg_score;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dbg_score <= '0;
        end else if (32'(i_dbg_idx) < NUM_CLASS) begin
            r_dbg_score <= r_buf[i_dbg_idx];
        end else begin
            r_dbg_score <= '0;
        end
    end

    assign o_dbg_score = r_dbg_score;
`endif

endmodule

// File: tb/tb_cnn_result_argmax.sv
// Directed scoreboard bench for cnn_result_argmax (debug port checks when CNN_ARGMAX_DBG_EN is set).
module tb_cnn_result_argmax;
    import cnn_pkg::*;

    localparam int N = 10;
    localparam int IW = 4;

    typedef struct {
        logic [IW-1:0] idx;
        logic [31:0]   score;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res [N-1:0];
    logic          cls_valid;
    logic          cls_ready;
    logic [IW-1:0] cls_idx;
    logic [31:0]   cls_score;
`ifdef CNN_ARGMAX_DBG_EN
    logic [IW-1:0] dbg_idx;
    logic [31:0]   dbg_score;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    cnn_result_argmax #(.NUM_CLASS(N), .DATA_W(32), .IDX_W(IW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_res_valid(res_valid),
        .o_res_ready(res_ready),
        .i_res      (res),
        .o_cls_valid(cls_valid),
        .i_cls_ready(cls_ready),
        .o_cls_idx  (cls_idx),
`ifdef CNN_ARGMAX_DBG_EN
        .o_cls_score(cls_score),
        .i_dbg_idx  (dbg_idx),
        .o_dbg_score(dbg_score)
`else
        .o_cls_score(cls_score)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] s [0:N-1]);
        exp_t r;
        r.idx   = '0;
        r.score = s[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(s[i]) > $signed(r.score)) begin
                r.idx   = IW'(i);
                r.score = s[i];
            end
        end
        return r;
    endfunction

    // Offer a frame, wait (bounded) for acceptance, then scramble i_res.
    task automatic send(input logic [31:0] s [0:N-1], input bit push);
        int n = 0;
        for (int i = 0; i < N; i++) res[i] = s[i];
        res_valid = 1'b1;
        while (!res_ready && n < 60) begin
            step();
            n++;
        end
        chk("accept_timeout", 32'(res_ready), 32'd1);
        step();
        res_valid = 1'b0;
        for (int i = 0; i < N; i++) res[i] = 32'h7fff_ffff;
        if (push) sb.push_back(model(s));
    endtask

    task automatic wait_result();
        int n = 0;
        while (!cls_valid && n < 40) begin
            step();
            n++;
        end
        chk("valid_seen", 32'(cls_valid), 32'd1);
        chk("latency", 32'(n), 32'(N - 1));
        chk("ready_in_hold", 32'(res_ready), 32'd0);
    endtask

    task automatic consume();
        exp_t e;
        cls_ready = 1'b1;
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cls_idx", 32'(cls_idx), 32'(e.idx));
            chk("cls_score", cls_score, e.score);
        end
        step();
        chk("valid_after_accept", 32'(cls_valid), 32'd0);
        chk("ready_after_accept", 32'(res_ready), 32'd1);
    endtask

    initial begin
        logic [31:0]   f [0:N-1];
        logic [31:0]   g [0:N-1];
        logic [IW-1:0] hold_idx;
        logic [31:0]   hold_score;
        bit            stable;
        bit            seen;

        rst       = 1'b1;
        res_valid = 1'b0;
        cls_ready = 1'b1;
        for (int i = 0; i < N; i++) res[i] = '0;
`ifdef CNN_ARGMAX_DBG_EN
        dbg_idx = '0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_valid", 32'(cls_valid), 32'd0);
        chk("rst_idx", 32'(cls_idx), 32'd0);
        chk("rst_score", cls_score, 32'd0);

        // Ascending scores
        f = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        send(f, 1'b1);
        wait_result();
        consume();
`ifdef CNN_ARGMAX_DBG_EN
        dbg_idx = 4'd6;
        step();
        chk("dbg_6", dbg_score, 32'd6);
        dbg_idx = 4'd12;
        step();
        chk("dbg_oob", dbg_score, 32'd0);
`endif

        // Tie keeps lower index
        f = '{5, -3, 100, 100, 7, 0, 0, 0, 0, -1};
        send(f, 1'b1);
        wait_result();
        consume();

        // All signed minimum
        for (int i = 0; i < N; i++) f[i] = 32'h8000_0000;
        send(f, 1'b1);
        wait_result();
        consume();

        // All negative
        f = '{-10, -2, -7, -3, -4, -5, -6, -8, -11, -9};
        send(f, 1'b1);
        wait_result();
        consume();

        // Backpressure with a second frame offered during HOLD
        cls_ready = 1'b0;
        f = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
        send(f, 1'b1);
        wait_result();
        hold_idx   = cls_idx;
        hold_score = cls_score;
        g = '{1, 2, 3, 4, 5, 6, 7, 8, 77, -77};
        for (int i = 0; i < N; i++) res[i] = g[i];
        res_valid = 1'b1;
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!cls_valid || res_ready || cls_idx !== hold_idx || cls_score !== hold_score)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_idx", 32'(hold_idx), 32'd5);
        consume();
        send(g, 1'b1);
        wait_result();
        consume();

        // Reset mid-scan discards the frame
        f = '{50, 60, 70, 80, 90, 1, 2, 3, 4, 5};
        send(f, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ready", 32'(res_ready), 32'd1);
        chk("midrst_valid", 32'(cls_valid), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (cls_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", 32'(seen), 32'd0);
        f = '{0, 0, 0, 42, 0, 0, 0, 0, 0, 0};
        send(f, 1'b1);
        wait_result();
        consume();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
